// File: rtl/ast_word_arbiter_pkg.sv
// Shared types and constants for the Avalon-ST word arbiter.
// The word type is sized for the default build.
package ast_arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_BYTE_W       = 8;
    localparam int DEF_DATA_SYMBOLS = 6;
    localparam int PKT_CNT_W        = 32;

    typedef logic [DEF_DATA_SYMBOLS-1:0][DEF_BYTE_W-1:0] word_t;
endpackage

// File: rtl/ast_word_arbiter_if.sv
// Requester, sender and status signals of ast_word_arbiter in one bundle.
// master is the arbiter side; slave is the surrounding logic.
interface ast_word_arbiter_if
    import ast_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BYTE_W       = 8,
    parameter int DATA_SYMBOLS = 6,
    parameter int TAG_W        = $clog2(NUM_REQ)
);
    // Handshakes: a requester word moves when req_valid_i[i] & req_ready_o[i]
    // at a rising edge; req_ready_o is a one-hot, one-cycle acknowledge.
    // The sender takes data_o on the single-cycle data_valid_o pulse, which
    // is only raised after sender_ready_i was seen high at grant time.
    logic [NUM_REQ-1:0][DATA_SYMBOLS-1:0][BYTE_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]                               req_valid_i;
    logic [NUM_REQ-1:0]                               req_en_i;
    logic [NUM_REQ-1:0]                               req_ready_o;
    logic [DATA_SYMBOLS-1:0][BYTE_W-1:0]              data_o;
    logic                                             data_valid_o;
    logic                                             sender_ready_i;
    logic                                             mon_valid_i;
    logic                                             mon_ready_i;
    logic                                             mon_eop_i;
    logic [TAG_W-1:0]                                 tag_o;
    logic                                             busy_o;
    logic [PKT_CNT_W-1:0]                             pkt_cnt_o;
    logic                                             err_wdog_o;
    logic                                             err_clr_i;
    state_t                                           state_o;

    modport master (
        input  req_data_i, req_valid_i, req_en_i, sender_ready_i,
        input  mon_valid_i, mon_ready_i, mon_eop_i, err_clr_i,
        output req_ready_o, data_o, data_valid_o, tag_o, busy_o,
        output pkt_cnt_o, err_wdog_o, state_o
    );

    modport slave (
        output req_data_i, req_valid_i, req_en_i, sender_ready_i,
        output mon_valid_i, mon_ready_i, mon_eop_i, err_clr_i,
        input  req_ready_o, data_o, data_valid_o, tag_o, busy_o,
        input  pkt_cnt_o, err_wdog_o, state_o
    );
endinterface

// File: rtl/ast_word_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of elig_i at or above ptr_i,
// wrapping around. Reusable by any arbiter.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     elig_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any_o && elig_i[(int'(ptr_i) + k) % N]) begin
                any_o                           = 1'b1;
                grant_o[(int'(ptr_i) + k) % N]  = 1'b1;
                idx_o                           = IDX_W'((int'(ptr_i) + k) % N);
            end
        end
    end
endmodule

// File: rtl/ast_word_arbiter.sv
// Round-robin arbiter sharing one Avalon-ST word sender between NUM_REQ
// producers; tracks packet completion, counts packets and watches for stalls.
module ast_word_arbiter
    import ast_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BYTE_W       = 8,
    parameter int DATA_SYMBOLS = 6,
    parameter int TAG_W        = $clog2(NUM_REQ),
    parameter int WDOG_W       = 8
) (
    input  logic               clk_i,
    input  logic               arst_i,
    ast_word_arbiter_if.master bus
);
    typedef logic [DATA_SYMBOLS-1:0][BYTE_W-1:0] arb_word_t;
    localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

    state_t               state_q, state_d;
    arb_word_t            data_q, data_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [TAG_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;
    logic                 err_q, err_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    logic [NUM_REQ-1:0] elig, pick_grant;
    logic [TAG_W-1:0]   pick_idx;
    logic               pick_any, grant_en, beat, eop_beat, err_set;

    assign elig = bus.req_valid_i & bus.req_en_i;

    rr_pick #(.N(NUM_REQ), .IDX_W(TAG_W)) u_pick (
        .elig_i  (elig),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign grant_en = (state_q == ST_IDLE) && bus.sender_ready_i && pick_any;
    assign beat     = bus.mon_valid_i && bus.mon_ready_i;
    assign eop_beat = beat && bus.mon_eop_i;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        tag_d     = tag_q;
        rr_ptr_d  = rr_ptr_q;
        wdog_d    = wdog_q;
        pkt_cnt_d = pkt_cnt_q;
        err_set   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wdog_d = '0;
                if (grant_en) begin
                    data_d   = bus.req_data_i[pick_idx];
                    tag_d    = pick_idx;
                    rr_ptr_d = (pick_idx == TAG_W'(NUM_REQ - 1)) ? '0 : pick_idx + TAG_W'(1);
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wdog_d  = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (eop_beat) begin
                    pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
                    wdog_d    = '0;
                    state_d   = ST_IDLE;
                end else if (beat) begin
                    wdog_d = '0;
                end else if (wdog_q != WDOG_MAX) begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
                // Flag only on the cycle the counter first saturates, so a
                // clear during a long stall is not immediately overridden.
                err_set = !eop_beat && (wdog_q != WDOG_MAX) && (wdog_d == WDOG_MAX);
            end
            default: state_d = ST_IDLE;
        endcase
        err_d = err_set ? 1'b1 : (bus.err_clr_i ? 1'b0 : err_q);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            tag_q     <= '0;
            rr_ptr_q  <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
            rr_ptr_q  <= rr_ptr_d;
            wdog_q    <= wdog_d;
            err_q     <= err_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign bus.req_ready_o  = grant_en ? pick_grant : '0;
    assign bus.data_o       = data_q;
    assign bus.data_valid_o = (state_q == ST_ISSUE);
    assign bus.tag_o        = tag_q;
    assign bus.busy_o       = (state_q != ST_IDLE);
    assign bus.pkt_cnt_o    = pkt_cnt_q;
    assign bus.err_wdog_o   = err_q;
    assign bus.state_o      = state_q;
endmodule

// File: tb/tb_ast_word_arbiter.sv
// Directed bench for ast_word_arbiter with a 1-symbol, 6-beat sender model.
module tb_ast_word_arbiter;
    import ast_arb_pkg::*;

    logic clk = 1'b0;
    logic arst = 1'b1;
    logic sink_ready = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   grant_cnt = 0;
    logic [1:0] exp_q[$];

    ast_word_arbiter_if #(.NUM_REQ(4), .BYTE_W(8), .DATA_SYMBOLS(6)) bus ();

    ast_word_arbiter #(.NUM_REQ(4), .BYTE_W(8), .DATA_SYMBOLS(6), .WDOG_W(8)) dut (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- sender model ----------------
    logic snd_busy;
    int   snd_beat;
    always @(posedge clk or posedge arst) begin
        if (arst) begin
            snd_busy <= 1'b0;
            snd_beat <= 0;
        end else if (!snd_busy) begin
            if (bus.data_valid_o) begin
                snd_busy <= 1'b1;
                snd_beat <= 0;
            end
        end else if (bus.mon_valid_i && bus.mon_ready_i) begin
            if (snd_beat == 5) snd_busy <= 1'b0;
            else snd_beat <= snd_beat + 1;
        end
    end
    assign bus.sender_ready_i = !snd_busy;
    assign bus.mon_valid_i    = snd_busy;
    assign bus.mon_ready_i    = sink_ready;
    assign bus.mon_eop_i      = snd_busy && (snd_beat == 5);

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- grant scoreboard ----------------
    int   last_grant;
    logic have_last;
    always @(negedge clk or posedge arst) begin
        if (arst) begin
            have_last = 1'b0;
        end else if (|bus.req_ready_o) begin
            int idx;
            idx = 0;
            for (int i = 0; i < 4; i++) if (bus.req_ready_o[i]) idx = i;
            check("grant_onehot", 64'($countones(bus.req_ready_o)), 64'd1);
            if (exp_q.size() == 0) begin
                check("grant_expected", 64'(exp_q.size()), 64'd1);
            end else begin
                check("grant_order", 64'(idx), 64'(exp_q.pop_front()));
            end
            if (have_last) check("grant_gap_ge8", 64'(cyc - last_grant >= 8), 64'd1);
            last_grant = cyc;
            have_last  = 1'b1;
            grant_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        arst                 = 1'b1;
        bus.req_valid_i      = '0;
        bus.req_en_i         = 4'b1111;
        bus.req_data_i       = '0;
        bus.err_clr_i        = 1'b0;
        sink_ready           = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_dv", 64'(bus.data_valid_o), 64'd0);
        check("rst_data", 64'(bus.data_o), 64'd0);
        check("rst_tag", 64'(bus.tag_o), 64'd0);
        check("rst_pkt", 64'(bus.pkt_cnt_o), 64'd0);
        check("rst_err", 64'(bus.err_wdog_o), 64'd0);
        check("rst_state", 64'(bus.state_o), 64'(ST_IDLE));
        arst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int start, c;
        start = grant_cnt;
        c = 0;
        while ((grant_cnt - start) < n && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        check("grant_count", 64'(grant_cnt - start), 64'(n));
    endtask

    task automatic drop_valids();
        @(posedge clk);
        #1;
        bus.req_valid_i = '0;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        @(negedge clk);
        while (bus.busy_o && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("idle_reached", 64'(bus.busy_o), 64'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [47:0] w;
        int c;
        w = 48'h0A0B0C0D0E0F;

        // single requester 2
        do_reset();
        exp_q.push_back(2'd2);
        bus.req_data_i[2] = w;
        bus.req_valid_i   = 4'b0100;
        @(negedge clk);
        check("t1_ready", 64'(bus.req_ready_o), 64'b0100);
        drop_valids();
        @(negedge clk);
        check("t1_dv", 64'(bus.data_valid_o), 64'd1);
        check("t1_data", 64'(bus.data_o), 64'(w));
        check("t1_tag", 64'(bus.tag_o), 64'd2);
        @(negedge clk);
        check("t1_dv_pulse", 64'(bus.data_valid_o), 64'd0);
        check("t1_data_hold", 64'(bus.data_o), 64'(w));
        wait_idle(100);
        check("t1_pkt", 64'(bus.pkt_cnt_o), 64'd1);
        check("t1_tag_hold", 64'(bus.tag_o), 64'd2);

        // all four held valid for 8 packets
        do_reset();
        for (int p = 0; p < 8; p++) exp_q.push_back(2'(p % 4));
        for (int i = 0; i < 4; i++) bus.req_data_i[i] = 48'(i + 1);
        bus.req_valid_i = 4'b1111;
        wait_grants(8, 200);
        drop_valids();
        wait_idle(100);
        check("t2_pkt", 64'(bus.pkt_cnt_o), 64'd8);
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // requester 2 disabled
        do_reset();
        bus.req_en_i = 4'b1011;
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
        bus.req_valid_i = 4'b1111;
        wait_grants(6, 200);
        drop_valids();
        wait_idle(100);
        check("t3_pkt", 64'(bus.pkt_cnt_o), 64'd6);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // watchdog
        do_reset();
        exp_q.push_back(2'd0);
        sink_ready      = 1'b0;
        bus.req_valid_i = 4'b0001;
        wait_grants(1, 20);
        drop_valids();
        repeat (256) @(negedge clk);
        check("t4_err_before", 64'(bus.err_wdog_o), 64'd0);
        @(negedge clk);
        check("t4_err_set", 64'(bus.err_wdog_o), 64'd1);
        check("t4_state_busy", 64'(bus.state_o), 64'(ST_BUSY));
        repeat (5) @(negedge clk);
        check("t4_still_busy", 64'(bus.state_o), 64'(ST_BUSY));
        sink_ready = 1'b1;
        wait_idle(100);
        check("t4_pkt", 64'(bus.pkt_cnt_o), 64'd1);
        check("t4_err_sticky", 64'(bus.err_wdog_o), 64'd1);
        @(posedge clk); #1;
        bus.err_clr_i = 1'b1;
        @(posedge clk); #1;
        bus.err_clr_i = 1'b0;
        @(negedge clk);
        check("t4_err_clr", 64'(bus.err_wdog_o), 64'd0);

        // reset mid-packet
        do_reset();
        exp_q.push_back(2'd2);
        bus.req_data_i[2] = w;
        bus.req_valid_i   = 4'b0100;
        wait_grants(1, 20);
        drop_valids();
        c = 0;
        while (!(snd_busy && snd_beat == 3) && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("t5_beat3", 64'(snd_beat), 64'd3);
        arst = 1'b1;
        #1;
        check("t5_busy0", 64'(bus.busy_o), 64'd0);
        check("t5_data0", 64'(bus.data_o), 64'd0);
        check("t5_tag0", 64'(bus.tag_o), 64'd0);
        check("t5_dv0", 64'(bus.data_valid_o), 64'd0);
        @(negedge clk);
        arst = 1'b0;
        exp_q.delete();
        exp_q.push_back(2'd0);
        @(posedge clk); #1;
        bus.req_valid_i = 4'b1111;
        wait_grants(1, 20);
        drop_valids();
        wait_idle(100);
        check("t5_pkt", 64'(bus.pkt_cnt_o), 64'd1);

        // requester 1 valid only while sender busy
        do_reset();
        exp_q.push_back(2'd0);
        bus.req_valid_i = 4'b0001;
        wait_grants(1, 20);
        drop_valids();
        repeat (2) @(negedge clk);
        bus.req_valid_i = 4'b0010;
        repeat (3) @(negedge clk);
        bus.req_valid_i = 4'b0000;
        wait_idle(100);
        repeat (5) @(negedge clk);
        check("t6_pkt", 64'(bus.pkt_cnt_o), 64'd1);
        check("t6_no_grant", 64'(bus.req_ready_o), 64'd0);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
